// File: rtl/piso_tx_4.sv
// -----------------------------------------------------------------------------
// piso_tx_4 -- 4-bit parallel-in / serial-out frame transmitter.
//
// A parallel word is captured on load while idle and sent as one frame:
//   start bit (0), four data bits, optional even-parity bit, stop bit (1).
// Each bit lasts one En period (one clk edge with En=1). All outputs are
// registered. done pulses for one clk when the stop bit completes.
//
// Parameters:
//   MSB_FIRST  1: send D[3] first, 0: send D[0] first.
//
// Configuration macro:
//   PISO_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit (7-bit frame). When
//                      undefined, the frame is 6 bits long.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   En     in   bit-tick enable
//   load   in   parallel-load request (accepted only while idle)
//   D      in   [3:0] parallel word
//   ready  out  idle, load will be accepted
//   busy   out  frame in progress (complement of ready)
//   sout   out  serial line, idles high
//   done   out  one-clk pulse at frame completion
// -----------------------------------------------------------------------------
module piso_tx_4 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic       load,
  input  logic [3:0] D,
  output logic       ready,
  output logic       busy,
  output logic       sout,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PISO_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] shreg_q, shreg_d;
  logic [1:0] cnt_q, cnt_d;
  logic       sout_q, sout_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef PISO_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  // The bit at the head of the shift register is the one sent next; after a
  // shift, the following bit sits one position further in.
  logic       head_bit;
  logic       next_bit;
  logic [3:0] shifted;

  assign head_bit = MSB_FIRST ? shreg_q[3] : shreg_q[0];
  assign next_bit = MSB_FIRST ? shreg_q[2] : shreg_q[1];
  assign shifted  = MSB_FIRST ? {shreg_q[2:0], 1'b0} : {1'b0, shreg_q[3:1]};

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Capture does not wait for En; the start bit then lasts until the
        // next En tick.
        if (load) begin
          state_d = S_START;
          shreg_d = D;
          cnt_d   = 2'd0;
          sout_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef PISO_TX_PARITY_EN
          par_d   = ^D;
`endif
        end
      end

      S_START: begin
        if (En) begin
          state_d = S_DATA;
          cnt_d   = 2'd0;
          sout_d  = head_bit;
        end
      end

      S_DATA: begin
        if (En) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef PISO_TX_PARITY_EN
            state_d = S_PARITY;
            sout_d  = par_q;
`else
            state_d = S_STOP;
            sout_d  = 1'b1;
`endif
          end else begin
            sout_d = next_bit;
          end
        end
      end

`ifdef PISO_TX_PARITY_EN
      S_PARITY: begin
        if (En) begin
          state_d = S_STOP;
          sout_d  = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (En) begin
          state_d = S_IDLE;
          sout_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        sout_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is ordinary control flops, not a memory
      // array, so it is reset along with the rest of the state.
      state_q <= S_IDLE;
      shreg_q <= 4'b0000;
      cnt_q   <= 2'd0;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign sout  = sout_q;
  assign done  = done_q;

endmodule
